scanlines_pro: RTL and testbench

SCANLINES_PRO -- requirements
Module: scanlines_pro

---
 rtl/scanlines_pro.sv | 159 +++++++++++++++
 tb/tb_scanlines_pro.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scanlines_pro.sv
// Scanline filter: darkens selected line and/or column phases of an RGB video stream.
// Two-stage pipeline; configuration is sampled only at the start of each frame.
module scanlines_pro #(
   parameter int unsigned CW = 8
) (
   input  logic            clk_vid,
   input  logic            reset,
   input  logic [1:0]      scnl_mode,
   input  logic [3:0]      scnl_level,
   input  logic [2:0]      scnl_pitch,
   input  logic [1:0]      scnl_thick,
   input  logic            scnl_alt,
   input  logic [3*CW-1:0] core_rgb,
   input  logic            core_hs,
   input  logic            core_vs,
   input  logic            core_de,
   output logic [3*CW-1:0] scnl_rgb,
   output logic            scnl_hs,
   output logic            scnl_vs,
   output logic            scnl_de
);

   // Group size minus one: G-1 = pitch+1.
   function automatic logic [3:0] f_gm1(input logic [2:0] pitch);
      return {1'b0, pitch} + 4'd1;
   endfunction

   // Dark count D = min(thick+1, G-1).
   function automatic logic [3:0] f_dcnt(input logic [2:0] pitch, input logic [1:0] thick);
      logic [3:0] t1;
      t1 = {2'b00, thick} + 4'd1;
      return (t1 < f_gm1(pitch)) ? t1 : f_gm1(pitch);
   endfunction

   logic            r_vs_prev;
   logic            r_de_prev;
   logic            r_armed;
   logic            r_field;
   logic [1:0]      r_mode;
   logic [3:0]      r_level;
   logic [2:0]      r_pitch;
   logic [1:0]      r_thick;
   logic [3:0]      r_yph;
   logic [3:0]      r_xph;

   logic [3:0]      w_gm1;
   logic [3:0]      w_dcnt;
   logic [3:0]      w_d_new;
   logic [3:0]      w_off_new;
   logic [3:0]      w_xph;
   logic            w_field_new;
   logic            w_vs_rise;
   logic            w_de_rise;
   logic            w_de_fall;
   logic            w_dark;

   logic [3*CW-1:0] r1_rgb;
   logic            r1_hs;
   logic            r1_vs;
   logic            r1_de;
   logic            r1_dark;
   logic [4:0]      r1_mul;

   logic [CW+4:0]   w_prod [3];
   logic [3*CW-1:0] w_dim;
   logic            w_unused_prod;

   // r_armed masks edges on the first cycle after reset so levels already high do not count.
   always_comb begin
      w_vs_rise   = core_vs & ~r_vs_prev & r_armed;
      w_de_rise   = core_de & ~r_de_prev & r_armed;
      w_de_fall   = ~core_de & r_de_prev;
      w_gm1       = f_gm1(r_pitch);
      w_dcnt      = f_dcnt(r_pitch, r_thick);
      w_field_new = ~r_field;
      w_d_new     = f_dcnt(scnl_pitch, scnl_thick);
      w_off_new   = (scnl_alt & w_field_new) ? w_d_new : 4'd0;
      w_xph       = w_de_rise ? 4'd0 : r_xph;
      w_dark      = (r_mode[0] & (r_yph < w_dcnt)) | (r_mode[1] & (w_xph < w_dcnt));
   end

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         r_vs_prev <= 1'b0;
         r_de_prev <= 1'b0;
         r_armed   <= 1'b0;
         r_field   <= 1'b0;
         r_mode    <= 2'd0;
         r_level   <= 4'd0;
         r_pitch   <= 3'd0;
         r_thick   <= 2'd0;
         r_yph     <= 4'd0;
         r_xph     <= 4'd0;
      end else begin
         r_vs_prev <= core_vs;
         r_de_prev <= core_de;
         r_armed   <= 1'b1;
         if (w_vs_rise) begin
            r_mode  <= scnl_mode;
            r_level <= scnl_level;
            r_pitch <= scnl_pitch;
            r_thick <= scnl_thick;
            r_field <= w_field_new;
            r_yph   <= w_off_new;
         end else if (w_de_fall) begin
            r_yph <= (r_yph >= w_gm1) ? 4'd0 : r_yph + 4'd1;
         end
         if (core_de) begin
            r_xph <= (w_xph >= w_gm1) ? 4'd0 : w_xph + 4'd1;
         end
      end
   end

   // Stage 1: register the pixel with its dark decision and its scale factor 16-L.
   always_ff @(posedge clk_vid) begin
      if (reset) begin
         r1_rgb  <= '0;
         r1_hs   <= 1'b0;
         r1_vs   <= 1'b0;
         r1_de   <= 1'b0;
         r1_dark <= 1'b0;
         r1_mul  <= 5'd16;
      end else begin
         r1_rgb  <= core_rgb;
         r1_hs   <= core_hs;
         r1_vs   <= core_vs;
         r1_de   <= core_de;
         r1_dark <= w_dark;
         r1_mul  <= 5'd16 - {1'b0, r_level};
      end
   end

   // (c * (16-L)) >> 4 per channel; the top product bit is always zero.
   always_comb begin
      w_prod        = '{default: '0};
      w_dim         = '0;
      w_unused_prod = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         w_prod[ch]          = {5'b00000, r1_rgb[ch*CW +: CW]} * {{CW{1'b0}}, r1_mul};
         w_dim[ch*CW +: CW]  = w_prod[ch][CW+3:4];
         w_unused_prod       = w_unused_prod ^ w_prod[ch][CW+4] ^ (^w_prod[ch][3:0]);
      end
   end

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         scnl_rgb <= '0;
         scnl_hs  <= 1'b0;
         scnl_vs  <= 1'b0;
         scnl_de  <= 1'b0;
      end else begin
         scnl_rgb <= !r1_de ? '0 : (r1_dark ? w_dim : r1_rgb);
         scnl_hs  <= r1_hs;
         scnl_vs  <= r1_vs;
         scnl_de  <= r1_de;
      end
   end

endmodule

// File: tb/tb_scanlines_pro.sv
// Bench for scanlines_pro: frame-level reference model checked every cycle, plus
// literal spot checks on selected output pixels.
module tb_scanlines_pro;
   localparam int CW = 8;
   localparam int W  = 3 * CW;

   logic          clk_vid = 1'b0;
   logic          reset;
   logic [1:0]    scnl_mode;
   logic [3:0]    scnl_level;
   logic [2:0]    scnl_pitch;
   logic [1:0]    scnl_thick;
   logic          scnl_alt;
   logic [W-1:0]  core_rgb;
   logic          core_hs, core_vs, core_de;
   logic [W-1:0]  scnl_rgb;
   logic          scnl_hs, scnl_vs, scnl_de;

   always #5 clk_vid = ~clk_vid;

   scanlines_pro #(.CW(CW)) dut (
      .clk_vid    (clk_vid),
      .reset      (reset),
      .scnl_mode  (scnl_mode),
      .scnl_level (scnl_level),
      .scnl_pitch (scnl_pitch),
      .scnl_thick (scnl_thick),
      .scnl_alt   (scnl_alt),
      .core_rgb   (core_rgb),
      .core_hs    (core_hs),
      .core_vs    (core_vs),
      .core_de    (core_de),
      .scnl_rgb   (scnl_rgb),
      .scnl_hs    (scnl_hs),
      .scnl_vs    (scnl_vs),
      .scnl_de    (scnl_de)
   );

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   logic [W+2:0] exp1 = '0;
   logic [W+2:0] exp2 = '0;
   logic [W-1:0] out_px [64];
   logic [W-1:0] g_rgb = '0;
   bit           g_rand = 1'b0;

   // Model state: field, config latched at frame start, line/pixel index within frame/line.
   bit m_armed, m_pvs, m_pde, m_field;
   int m_mode, m_level, m_g, m_d, m_off, m_line, m_pix;

   task automatic model_reset();
      m_armed = 0; m_pvs = 0; m_pde = 0; m_field = 0;
      m_mode = 0; m_level = 0; m_g = 2; m_d = 1; m_off = 0; m_line = 0; m_pix = 0;
   endtask

   function automatic logic [W+2:0] model_out(logic vs, logic hs, logic de, logic [W-1:0] rgb);
      bit rise_de;
      bit dark;
      int px;
      logic [W-1:0] o;
      rise_de = de && !m_pde && m_armed;
      px = rise_de ? 0 : m_pix;
      dark = (((m_mode & 1) != 0) && (((m_off + m_line) % m_g) < m_d)) ||
             (((m_mode & 2) != 0) && ((px % m_g) < m_d));
      o = rgb;
      if (dark)
         for (int c = 0; c < 3; c++)
            o[c*CW +: CW] = CW'((int'(rgb[c*CW +: CW]) * (16 - m_level)) / 16);
      if (!de) o = '0;
      return {o, hs, vs, de};
   endfunction

   task automatic model_step(logic vs, logic de);
      bit rise_vs, rise_de, fall_de;
      rise_vs = vs && !m_pvs && m_armed;
      rise_de = de && !m_pde && m_armed;
      fall_de = !de && m_pde;
      if (de) m_pix = (rise_de ? 0 : m_pix) + 1;
      if (rise_vs) begin
         m_field = !m_field;
         m_mode  = int'(scnl_mode);
         m_level = int'(scnl_level);
         m_g     = int'(scnl_pitch) + 2;
         m_d     = (int'(scnl_thick) + 1 < m_g - 1) ? int'(scnl_thick) + 1 : m_g - 1;
         m_off   = (scnl_alt && m_field) ? m_d : 0;
         m_line  = 0;
      end else if (fall_de) begin
         m_line++;
      end
      m_pvs = vs; m_pde = de; m_armed = 1;
   endtask

   function automatic logic [W-1:0] rnd();
      return W'($urandom);
   endfunction

   task automatic cyc(logic rst, logic vs, logic hs, logic de, logic [W-1:0] rgb);
      logic [W+2:0] e;
      reset = rst; core_vs = vs; core_hs = hs; core_de = de; core_rgb = rgb;
      e = model_out(vs, hs, de, rgb);
      @(posedge clk_vid);
      if (rst) begin
         exp1 = '0; exp2 = '0;
         model_reset();
      end else begin
         exp2 = exp1; exp1 = e;
         model_step(vs, de);
      end
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, rnd());
   endtask

   task automatic do_reset(int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, rnd());
   endtask

   task automatic vsync();
      cyc(0, 1, 0, 0, rnd()); cyc(0, 1, 0, 0, rnd());
      cyc(0, 0, 0, 0, rnd()); cyc(0, 0, 0, 0, rnd());
   endtask

   task automatic vline(int npix);
      cyc(0, 0, 1, 0, rnd()); cyc(0, 0, 0, 0, rnd());
      for (int i = 0; i < npix; i++) cyc(0, 0, 0, 1, g_rand ? rnd() : g_rgb);
      idle(3);
   endtask

   task automatic set_cfg(int mode, int level, int pitch, int thick, int alt);
      scnl_mode = 2'(mode); scnl_level = 4'(level); scnl_pitch = 3'(pitch);
      scnl_thick = 2'(thick); scnl_alt = 1'(alt);
   endtask

   task automatic lit(string name, logic [W-1:0] got, logic [W-1:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Every-cycle comparison against the model, plus capture of each output line.
   initial begin : compare
      int  o_idx;
      logic o_pde;
      o_idx = 0; o_pde = 1'b0;
      forever begin
         @(negedge clk_vid);
         if (chk_en) begin
            n_chk++;
            if ({scnl_rgb, scnl_hs, scnl_vs, scnl_de} !== exp2) begin
               n_err++;
               $display("FAIL stream @%0t: got rgb=%h hs=%b vs=%b de=%b, expected rgb=%h hs=%b vs=%b de=%b",
                        $time, scnl_rgb, scnl_hs, scnl_vs, scnl_de,
                        exp2[W+2:3], exp2[2], exp2[1], exp2[0]);
            end
            if (scnl_de === 1'b1) begin
               if (!o_pde) o_idx = 0;
               if (o_idx < 64) out_px[o_idx] = scnl_rgb;
               o_idx++;
            end
            o_pde = scnl_de;
         end
      end
   end

   initial begin
      set_cfg(0, 0, 0, 0, 0);
      model_reset();
      cyc(1, 0, 0, 0, '0);
      chk_en = 1'b1;
      do_reset(2);
      idle(3);

      // Horizontal, G=2 D=1, half brightness.
      set_cfg(1, 8, 0, 0, 0); g_rand = 0; g_rgb = 24'hFFFFFF;
      vsync();
      vline(4); lit("h_line0", out_px[0], 24'h7F7F7F);
      vline(4); lit("h_line1", out_px[2], 24'hFFFFFF);
      vline(4); lit("h_line2", out_px[3], 24'h7F7F7F);
      vline(4); lit("h_line3", out_px[0], 24'hFFFFFF);
      vline(4); lit("h_line4", out_px[1], 24'h7F7F7F);

      // Vertical, G=3 D=2, L=15.
      set_cfg(2, 15, 1, 3, 0); g_rgb = 24'h808080;
      vsync();
      for (int l = 0; l < 2; l++) begin
         vline(7);
         lit("v_col0", out_px[0], 24'h080808);
         lit("v_col2", out_px[2], 24'h808080);
         lit("v_col3", out_px[3], 24'h080808);
         lit("v_col5", out_px[5], 24'h808080);
      end

      // Alternating field shift.
      do_reset(2); idle(3);
      set_cfg(1, 8, 0, 0, 1); g_rgb = 24'hFFFFFF;
      vsync();
      vline(4); lit("alt_f1_l0", out_px[0], 24'hFFFFFF);
      vline(4); lit("alt_f1_l1", out_px[0], 24'h7F7F7F);
      vsync();
      vline(4); lit("alt_f2_l0", out_px[0], 24'h7F7F7F);
      vline(4); lit("alt_f2_l1", out_px[0], 24'hFFFFFF);

      // Mode change mid-frame takes effect at the next frame.
      do_reset(2); idle(3);
      set_cfg(0, 8, 0, 0, 0);
      vsync();
      vline(3);
      set_cfg(3, 8, 0, 0, 0);
      vline(3); lit("mid_l1_px0", out_px[0], 24'hFFFFFF);
      vline(3); lit("mid_l2_px1", out_px[1], 24'hFFFFFF);
      vsync();
      vline(3); lit("both_l0_px1", out_px[1], 24'h7F7F7F);
      vline(3);
      lit("both_l1_px0", out_px[0], 24'h7F7F7F);
      lit("both_l1_px1", out_px[1], 24'hFFFFFF);

      // Random sync and pixels with mode off, then with L=0.
      do_reset(2); idle(3);
      set_cfg(0, 5, 2, 1, 1);
      for (int i = 0; i < 200; i++)
         cyc(0, $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom), rnd());
      set_cfg(3, 0, 1, 2, 0);
      for (int i = 0; i < 200; i++)
         cyc(0, $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom), rnd());
      idle(3);

      // Reset mid-line with vs and de held high across it.
      do_reset(2); idle(3);
      set_cfg(1, 8, 0, 0, 0); g_rand = 0; g_rgb = 24'hFFFFFF;
      vsync();
      cyc(0, 0, 1, 0, rnd()); cyc(0, 0, 0, 0, rnd());
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, g_rgb);
      cyc(1, 1, 0, 1, g_rgb); cyc(1, 1, 0, 1, g_rgb);
      lit("rst_out_rgb", scnl_rgb, 24'h000000);
      lit("rst_out_de", {23'd0, scnl_de}, 24'h000000);
      cyc(0, 1, 0, 1, g_rgb);
      lit("post_rst1_rgb", scnl_rgb, 24'h000000);
      cyc(0, 1, 0, 1, g_rgb);
      lit("post_rst2_rgb", scnl_rgb, 24'hFFFFFF);
      cyc(0, 0, 0, 1, g_rgb); cyc(0, 0, 0, 1, g_rgb);
      idle(3);
      vline(4); lit("post_rst_pass", out_px[0], 24'hFFFFFF);
      vsync();
      vline(4); lit("post_rst_vs_dark", out_px[0], 24'h7F7F7F);

      // Random configurations across several frames, with mid-frame config noise.
      do_reset(2); idle(3);
      g_rand = 1;
      for (int f = 0; f < 8; f++) begin
         set_cfg($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7),
                 $urandom_range(0, 3), $urandom_range(0, 1));
         vsync();
         for (int l = 0; l < 5; l++) begin
            vline($urandom_range(3, 12));
            if (l == 1)
               set_cfg($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7),
                       $urandom_range(0, 3), $urandom_range(0, 1));
         end
      end
      idle(4);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
